// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 load/store constants and access checking
package rv32_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int RSP_DEPTH = 3;

    // Misalignment, unknown funct3 and unsigned-size stores all fault.
    function automatic logic access_fault(input logic store, input logic [2:0] funct3,
                                          input logic [1:0] off);
        case (funct3)
            F3_LB:   access_fault = 1'b0;
            F3_LH:   access_fault = off[0];
            F3_LW:   access_fault = (off != 2'b00);
            F3_LBU:  access_fault = store;
            F3_LHU:  access_fault = store | off[0];
            default: access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - small synchronous FIFO with occupancy count
module resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             pop;

    assign pop        = pop_ready && (count_q != '0);
    assign head_valid = (count_q != '0);
    // Head reads as zero when empty so the response bus is quiet between entries.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign count      = count_q;

    // Storage, wrap-around pointers and count; push while full is legal only alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_valid) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_valid, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 data-side adapter to a registered-read block RAM
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int RB_W = 33;

    logic            accept;
    logic            req_fault;
    logic [1:0]      req_off;
    logic [3:0]      we_mask;
    logic            s1_valid;
    logic            s1_store;
    logic            s1_fault;
    logic [2:0]      s1_funct3;
    logic [1:0]      s1_off;
    logic [31:0]     ld_shift;
    logic [31:0]     ld_data;
    logic [1:0]      rb_count;
    logic [RB_W-1:0] rb_head;

    assign req_off   = req_addr[1:0];
    assign req_fault = access_fault(req_store, req_funct3, req_off);
    // Room is reserved for the entry still in S1, so readiness needs only registered state.
    assign req_ready = ({1'b0, rb_count} + {2'b00, s1_valid}) < 3'(RSP_DEPTH);
    assign accept    = req_valid && req_ready && !rst;
    assign ram_addr  = req_addr[ADDR_WIDTH+1:2];

    // Byte-lane write mask and replicated write data for the store size.
    always_comb begin
        we_mask   = 4'b1111;
        ram_wdata = req_wdata;
        ram_we    = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                we_mask   = 4'b0001 << req_off;
                ram_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                we_mask   = 4'b0011 << req_off;
                ram_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                we_mask   = 4'b1111;
                ram_wdata = req_wdata;
            end
        endcase
        if (accept && req_store && !req_fault) begin
            ram_we = we_mask;
        end
    end

    // S1 holds the request attributes while the RAM produces its registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_store  <= 1'b0;
            s1_fault  <= 1'b0;
            s1_funct3 <= 3'b000;
            s1_off    <= 2'b00;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_store  <= req_store;
                s1_fault  <= req_fault;
                s1_funct3 <= req_funct3;
                s1_off    <= req_off;
            end
        end
    end

    assign ld_shift = ram_rdata >> {s1_off, 3'b000};

    // Align and extend the load result; stores and faults respond with zero.
    always_comb begin
        ld_data = 32'h0;
        if (!s1_store && !s1_fault) begin
            case (s1_funct3)
                F3_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
                F3_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
                F3_LW:   ld_data = ld_shift;
                F3_LBU:  ld_data = {24'h0, ld_shift[7:0]};
                F3_LHU:  ld_data = {16'h0, ld_shift[15:0]};
                default: ld_data = 32'h0;
            endcase
        end
    end

    resp_fifo #(
        .DEPTH(RSP_DEPTH),
        .WIDTH(RB_W)
    ) u_rb (
        .clk       (clk),
        .rst       (rst),
        .push_valid(s1_valid),
        .push_data ({ld_data, s1_fault}),
        .pop_ready (rsp_ready),
        .head_valid(rsp_valid),
        .head_data (rb_head),
        .count     (rb_count)
    );

    assign rsp_rdata = rb_head[RB_W-1:1];
    assign rsp_fault = rb_head[0];

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    import rv32_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [2:0]    req_funct3 = 3'b010;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [3:0]  last_we;
    logic [31:0] last_wd;
    int          last_acc;

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          c;
    } rsp_t;
    rsp_t rq[$];

    logic [31:0] mem [512];

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: byte writes and read-old-data registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    // Response monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_t r;
            r.d = rsp_rdata;
            r.f = rsp_fault;
            r.c = cyc;
            rq.push_back(r);
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [AW+1:0] a,
                         input logic [31:0] wd);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_store  = st;
            req_funct3 = f3;
            req_addr   = a;
            req_wdata  = wd;
            #1;
            got     = req_ready;
            last_we = ram_we;
            last_wd = ram_wdata;
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
        last_acc  = cyc;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout addr=%h req_ready never seen", a);
        end
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic f, output int c);
        rsp_t r;
        for (int i = 0; i < 40 && rq.size() == 0; i++) @(negedge clk);
        if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout got=none required=one response");
            d = 32'hxxxxxxxx;
            f = 1'bx;
            c = -1;
        end else begin
            r = rq.pop_front();
            d = r.d;
            f = r.f;
            c = r.c;
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        req_store = 1'b1;
        req_funct3 = F3_LW;
        req_addr = 11'h010;
        req_wdata = 32'h12345678;
        #12;
        checks++; if (ram_we !== 4'b0000) begin failures++; $display("FAIL rst_ram_we got=%b required=0000", ram_we); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b required=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h required=0", rsp_rdata); end
        checks++; if (rsp_fault !== 1'b0) begin failures++; $display("FAIL rst_rsp_fault got=%b required=0", rsp_fault); end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b required=1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic f;
        int c, a0, a1;
        issue(1'b1, F3_LW, 11'h010, 32'hDEADBEEF);
        a0 = last_acc;
        checks++; if (last_we !== 4'b1111) begin failures++; $display("FAIL sw_we got=%b required=1111", last_we); end
        checks++; if (last_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h required=deadbeef", last_wd); end
        issue(1'b0, F3_LW, 11'h010, 32'h0);
        a1 = last_acc;
        checks++; if (a1 !== a0 + 1) begin failures++; $display("FAIL b2b_accept got=%0d required=%0d", a1, a0 + 1); end
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'h0, 1'b0}) begin failures++; $display("FAIL sw_rsp got=%h/%b required=0/0", d, f); end
        checks++; if (c !== a0 + 1) begin failures++; $display("FAIL sw_latency got=%0d required=%0d", c, a0 + 1); end
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'hDEADBEEF, 1'b0}) begin failures++; $display("FAIL lw_rsp got=%h/%b required=deadbeef/0", d, f); end
        checks++; if (c !== a1 + 1) begin failures++; $display("FAIL lw_latency got=%0d required=%0d", c, a1 + 1); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3v [6];
        logic [10:0] adv [6];
        logic [31:0] exv [6];
        logic [31:0] d;
        logic f;
        int c;
        f3v = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LB, F3_LH};
        adv = '{11'h013, 11'h013, 11'h012, 11'h012, 11'h010, 11'h010};
        exv = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF, 32'hFFFFBEEF};
        for (int i = 0; i < 6; i++) issue(1'b0, f3v[i], adv[i], 32'h0);
        for (int i = 0; i < 6; i++) begin
            get_rsp(d, f, c);
            checks++;
            if ({d, f} !== {exv[i], 1'b0}) begin
                failures++;
                $display("FAIL load_ext_%0d got=%h/%b required=%h/0", i, d, f, exv[i]);
            end
        end
    endtask

    task automatic test_store_sub();
        logic [31:0] d;
        logic f;
        int c;
        issue(1'b1, F3_LB, 11'h011, 32'hAABBCC55);
        checks++; if (last_we !== 4'b0010) begin failures++; $display("FAIL sb_we got=%b required=0010", last_we); end
        checks++; if (last_wd !== 32'h55555555) begin failures++; $display("FAIL sb_wdata got=%h required=55555555", last_wd); end
        issue(1'b0, F3_LW, 11'h010, 32'h0);
        issue(1'b1, F3_LW, 11'h014, 32'hCAFEF00D);
        issue(1'b1, F3_LH, 11'h016, 32'h99991234);
        checks++; if (last_we !== 4'b1100) begin failures++; $display("FAIL sh_we got=%b required=1100", last_we); end
        checks++; if (last_wd !== 32'h12341234) begin failures++; $display("FAIL sh_wdata got=%h required=12341234", last_wd); end
        issue(1'b0, F3_LW, 11'h014, 32'h0);
        get_rsp(d, f, c);
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'hDEAD55EF, 1'b0}) begin failures++; $display("FAIL sb_readback got=%h/%b required=dead55ef/0", d, f); end
        get_rsp(d, f, c);
        get_rsp(d, f, c);
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'h1234F00D, 1'b0}) begin failures++; $display("FAIL sh_readback got=%h/%b required=1234f00d/0", d, f); end
    endtask

    task automatic test_faults();
        logic        stv [4];
        logic [2:0]  f3v [4];
        logic [10:0] adv [4];
        logic [31:0] d;
        logic f;
        int c;
        stv = '{1'b0, 1'b1, 1'b0, 1'b1};
        f3v = '{F3_LH, F3_LW, 3'b011, F3_LBU};
        adv = '{11'h011, 11'h012, 11'h010, 11'h010};
        for (int i = 0; i < 4; i++) begin
            issue(stv[i], f3v[i], adv[i], 32'h11111111);
            checks++;
            if (last_we !== 4'b0000) begin
                failures++;
                $display("FAIL fault_we_%0d got=%b required=0000", i, last_we);
            end
        end
        for (int i = 0; i < 4; i++) begin
            get_rsp(d, f, c);
            checks++;
            if ({d, f} !== {32'h0, 1'b1}) begin
                failures++;
                $display("FAIL fault_rsp_%0d got=%h/%b required=0/1", i, d, f);
            end
        end
        issue(1'b0, F3_LW, 11'h010, 32'h0);
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'hDEAD55EF, 1'b0}) begin failures++; $display("FAIL fault_mem got=%h/%b required=dead55ef/0", d, f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic f;
        int c, idx;
        logic got;
        for (int i = 0; i < 5; i++) issue(1'b1, F3_LW, 11'(32'h20 + 4 * i), 32'hA0A00000 + i);
        for (int i = 0; i < 5; i++) get_rsp(d, f, c);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (idx < 5) begin
                req_valid  = 1'b1;
                req_store  = 1'b0;
                req_funct3 = F3_LW;
                req_addr   = 11'(32'h20 + 4 * idx);
            end
            #1;
            got = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (got) idx++;
            req_valid = 1'b0;
        end
        checks++; if (idx !== 3) begin failures++; $display("FAIL bp_accepted got=%0d required=3", idx); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready got=%b required=0", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid got=%b required=1", rsp_valid); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5 && idx < 5; k++) begin
            issue(1'b0, F3_LW, 11'(32'h20 + 4 * idx), 32'h0);
            idx++;
        end
        for (int i = 0; i < 5; i++) begin
            get_rsp(d, f, c);
            checks++;
            if ({d, f} !== {32'hA0A00000 + 32'(i), 1'b0}) begin
                failures++;
                $display("FAIL bp_order_%0d got=%h/%b required=%h/0", i, d, f, 32'hA0A00000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        logic f;
        int c;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(1'b0, F3_LW, 11'h010, 32'h0);
        issue(1'b0, F3_LW, 11'h014, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered got=%b required=1", rsp_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b required=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL mid_async_rdata got=%h required=0", rsp_rdata); end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_req_ready got=%b required=1", req_ready); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rq.size() !== 0) begin failures++; $display("FAIL mid_stale got=%0d required=0 responses", rq.size()); end
        issue(1'b0, F3_LW, 11'h010, 32'h0);
        get_rsp(d, f, c);
        checks++; if ({d, f} !== {32'hDEAD55EF, 1'b0}) begin failures++; $display("FAIL mid_after got=%h/%b required=dead55ef/0", d, f); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_ext();
        test_store_sub();
        test_faults();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
